mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch port and the load/store data port of the MIPS CPU.
- Sequences each access through a fixed-latency memory and returns read data with a one-cycle ack pulse.
- Raises a stall to the PC and pipeline control while any request is still outstanding.
- Sits between the PC/instruction path, the ALU-addressed data path, and the physical memory macro.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and load/store.
// Optional round-robin arbitration between the two ports: define MEM_ARB_RR_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_grant_d;
  logic              r_we;
  logic              r_last_grant_d;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_grant_any;
  logic              w_grant_d;
  logic              w_capture;
  logic              w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_req || d_req) w_next_state = S_ACC;
      S_ACC:   if (w_cnt_zero) w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant decision and read-capture strobe; data wins by default to avoid fetch/data deadlock
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_d   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_any = i_req | d_req;
`ifdef MEM_ARB_RR_EN
        w_grant_d   = d_req & (~i_req | ~r_last_grant_d);
`else
        w_grant_d   = d_req;
`endif
      end
      S_ACC:   w_capture = w_cnt_zero;
      default: begin
        w_grant_any = 1'b0;
      end
    endcase
  end

  // Access datapath: latch on grant, strobe memory once, capture read data on the last ACC edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_grant_d      <= 1'b0;
      r_we           <= 1'b0;
      r_last_grant_d <= 1'b0;
      r_i_ack        <= 1'b0;
      r_d_ack        <= 1'b0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_i_ack  <= w_capture & ~r_grant_d;
      r_d_ack  <= w_capture & r_grant_d;
      if (w_grant_any) begin
        r_grant_d      <= w_grant_d;
        r_last_grant_d <= w_grant_d;
        r_we           <= w_grant_d & d_we;
        r_mem_en       <= 1'b1;
        r_mem_we       <= w_grant_d & d_we;
        r_mem_addr     <= w_grant_d ? d_addr : i_addr;
        if (w_grant_d) begin
          r_mem_wdata <= d_wdata;
        end
        r_cnt <= CNT_W'(MEM_LATENCY - 1);
      end else if ((r_state == S_ACC) && !w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        if (!r_grant_d) begin
          r_i_rdata <= mem_rdata;
        end else if (!r_we) begin
          r_d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign stall     = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a registered-read memory model (MEM_LATENCY = 2).
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack, mem_en, mem_we, stall, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .busy(busy)
  );

  // Memory: data is valid only in the single cycle after the strobe, garbage otherwise
  logic [DW-1:0] mem [logic [AW-1:0]];
  int unsigned   mcyc = 0;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h2002_0001;
  endfunction

  always @(posedge clock) begin
    mcyc <= mcyc + 1;
    if (mem_en) begin
      mem_rdata <= mem_read(mem_addr);
      if (mem_we) mem[mem_addr] = mem_wdata;
    end else begin
      mem_rdata <= 32'hBADB_AD00 ^ mcyc;
    end
  end

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any ack seen there
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (i_ack && d_ack) chk("dual_ack", 32'(1), 32'(0));
    if (i_ack || d_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(d_ack), 32'(e.is_d));
        chk("ack_data", d_ack ? d_rdata : i_rdata, e.data);
      end
    end
  endtask

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  // Run until n acks are scored, then release both requests
  task automatic run_acks(input int n, input bit chk_stall);
    int seen = 0;
    for (int k = 0; k < n * 6 + 10 && seen < n; k++) begin
      tick();
      if (chk_stall) chk("stall_held", 32'(stall), 32'(1));
      if (i_ack || d_ack) seen++;
    end
    if (seen < n) chk("ack_timeout", 32'(seen), 32'(n));
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset held two cycles with both requests asserted
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_i_ack", 32'(i_ack), 32'(0));
      chk("rst_d_ack", 32'(d_ack), 32'(0));
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
    end
    i_req = 1'b0; d_req = 1'b0;
    go(); reset = 1'b0;
    tick();

    // Fetch
    go(); i_req = 1'b1; i_addr = 32'h0000_0004;
    sb.push_back('{is_d: 1'b0, data: 32'h2002_0005});
    tick();
    chk("f_stall_T", 32'(stall), 32'(1));
    chk("f_busy_T", 32'(busy), 32'(0));
    tick();
    chk("f_en_T1", 32'(mem_en), 32'(1));
    chk("f_we_T1", 32'(mem_we), 32'(0));
    chk("f_addr_T1", mem_addr, 32'h4);
    chk("f_stall_T1", 32'(stall), 32'(1));
    tick();
    chk("f_en_T2", 32'(mem_en), 32'(0));
    chk("f_stall_T2", 32'(stall), 32'(1));
    chk("f_ack_T2", 32'(i_ack), 32'(0));
    tick();
    chk("f_ack_T3", 32'(i_ack), 32'(1));
    chk("f_stall_T3", 32'(stall), 32'(0));
    i_req = 1'b0;
    tick();
    chk("f_ack_T4", 32'(i_ack), 32'(0));
    chk("f_busy_T4", 32'(busy), 32'(0));

    // Simultaneous fetch and load: data first
    go(); i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    sb.push_back('{is_d: 1'b1, data: 32'h2002_0011});
    sb.push_back('{is_d: 1'b0, data: 32'h2002_0009});
    tick();
    tick();
    chk("s_en_T1", 32'(mem_en), 32'(1));
    chk("s_addr_T1", mem_addr, 32'h10);
    tick();
    tick();
    chk("s_dack_T3", 32'(d_ack), 32'(1));
    d_req = 1'b0;
    tick();
    chk("s_stall_T4", 32'(stall), 32'(1));
    tick();
    chk("s_en_T5", 32'(mem_en), 32'(1));
    chk("s_addr_T5", mem_addr, 32'h8);
    tick();
    tick();
    chk("s_iack_T7", 32'(i_ack), 32'(1));
    i_req = 1'b0;
    tick();

    // Store, then load back the stored word
    go(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    sb.push_back('{is_d: 1'b1, data: 32'h2002_0011});
    tick();
    tick();
    chk("st_en_T1", 32'(mem_en), 32'(1));
    chk("st_we_T1", 32'(mem_we), 32'(1));
    chk("st_addr_T1", mem_addr, 32'h20);
    chk("st_wdata_T1", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_en_T2", 32'(mem_en), 32'(0));
    chk("st_we_T2", 32'(mem_we), 32'(0));
    tick();
    chk("st_dack_T3", 32'(d_ack), 32'(1));
    d_req = 1'b0; d_we = 1'b0;
    tick();
    go(); d_req = 1'b1; d_addr = 32'h20;
    sb.push_back('{is_d: 1'b1, data: 32'hDEAD_BEEF});
    run_acks(1, 1'b0);
    tick();

    // Reset in the middle of an access
    go(); i_req = 1'b1; i_addr = 32'h30;
    tick();
    tick();
    reset = 1'b1; i_req = 1'b0;
    tick();
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_iack", 32'(i_ack), 32'(0));
    chk("mr_irdata", i_rdata, 32'h0);
    reset = 1'b0;
    tick();
    chk("mr_iack_after", 32'(i_ack), 32'(0));
    go(); i_req = 1'b1; i_addr = 32'h40;
    sb.push_back('{is_d: 1'b0, data: 32'h2002_0041});
    tick();
    tick();
    tick();
    chk("mr_ack_T2", 32'(i_ack), 32'(0));
    tick();
    chk("mr_ack_T3", 32'(i_ack), 32'(1));
    i_req = 1'b0;
    tick();

    // Both ports held for four grants
    go(); i_req = 1'b1; i_addr = 32'h50; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
`ifdef MEM_ARB_RR_EN
    sb.push_back('{is_d: 1'b1, data: 32'h2002_0061});
    sb.push_back('{is_d: 1'b0, data: 32'h2002_0051});
    sb.push_back('{is_d: 1'b1, data: 32'h2002_0061});
    sb.push_back('{is_d: 1'b0, data: 32'h2002_0051});
`else
    for (int g = 0; g < 4; g++) sb.push_back('{is_d: 1'b1, data: 32'h2002_0061});
`endif
    run_acks(4, 1'b1);
    for (int c = 0; c < 6; c++) tick();

    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("end_busy", 32'(busy), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
